vrf_wb_arbiter: RTL and testbench

- Owns the single write port (we3/v3/wd3) of register_file_vectorial and shares it between two producers: the vector ALU and the vector load/store unit (LSU).
- Round-robin arbitration with a valid/ready handshake per requester, plus one registered output stage that drives the register file.
- Contains a per-register in-flight scoreboard so decode can stall on read-after-write hazards for sources v1/v2.

---
 rtl/vrf_wb_arbiter_pkg.sv | 17 +
 rtl/vrf_wb_arbiter_if.sv | 18 +
 rtl/vrf_wb_arbiter_scoreboard.sv | 64 ++++++
 rtl/vrf_wb_arbiter.sv | 97 +++++++++
 tb/tb_vrf_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vrf_wb_arbiter_pkg.sv
// Shared defaults and types for the vector register-file write-back path.
package vrf_pkg;

  localparam int unsigned DefWidth       = 16;
  localparam int unsigned DefVectorSize  = 16;
  localparam int unsigned DefNumVectores = 16;
  localparam int unsigned DefIw          = $clog2(DefNumVectores);

  typedef logic [DefIw-1:0]    vreg_idx_t;
  typedef logic [DefWidth-1:0] vec_t [DefVectorSize];

  typedef enum logic {
    REQ_ALU,
    REQ_LSU
  } req_id_t;

endpackage

// File: rtl/vrf_wb_arbiter_if.sv
// Valid/ready write-back request from one producer (ALU or LSU).
interface vrf_wb_arbiter_if
  import vrf_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned VECTOR_SIZE = DefVectorSize,
  parameter int unsigned IW          = DefIw
);

  logic             valid;
  logic [IW-1:0]    vd;
  logic [WIDTH-1:0] data [VECTOR_SIZE];
  logic             ready;

  modport master (output valid, output vd, output data, input ready);
  modport slave  (input valid, input vd, input data, output ready);

endinterface

// File: rtl/vrf_wb_arbiter_scoreboard.sv
// Per-register in-flight counters: issue backpressure, RAW hazards, underflow flag.
module vrf_scoreboard #(
  parameter int unsigned NUM_VECTORES = 16,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned IW           = $clog2(NUM_VECTORES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [IW-1:0] issue_vd,
  output logic          issue_ready,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [IW-1:0] q_v1,
  input  logic [IW-1:0] q_v2,
  output logic          hazard_v1,
  output logic          hazard_v2,
  output logic          err_underflow
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [NUM_VECTORES];
  logic [CNT_W-1:0] cnt_d [NUM_VECTORES];
  logic             err_q, err_d;
  logic             inc, dec;

  // Ready looks only at the registered count, so a same-cycle commit cannot unstall.
  assign issue_ready   = (cnt_q[issue_vd] != CntMax);
  assign hazard_v1     = (q_v1 != '0) && (cnt_q[q_v1] != '0);
  assign hazard_v2     = (q_v2 != '0) && (cnt_q[q_v2] != '0);
  assign err_underflow = err_q;

  assign inc = issue_valid && issue_ready && (issue_vd != '0);
  assign dec = wr_en && (wr_idx != '0);

  always_comb begin
    cnt_d    = cnt_q;
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_VECTORES; r++) begin
      if (inc && (issue_vd == IW'(r)) && !(dec && (wr_idx == IW'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && (wr_idx == IW'(r)) && !(inc && (issue_vd == IW'(r)))) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Round-robin arbiter between ALU and LSU for the single vector register-file write port.
module vrf_wb_arbiter
  import vrf_pkg::*;
#(
  parameter  int unsigned WIDTH        = DefWidth,
  parameter  int unsigned VECTOR_SIZE  = DefVectorSize,
  parameter  int unsigned NUM_VECTORES = DefNumVectores,
  parameter  int unsigned CNT_W        = 2,
  localparam int unsigned IW           = $clog2(NUM_VECTORES)
) (
  input  logic             clk,
  input  logic             rst,
  vrf_wb_arbiter_if.slave  alu,
  vrf_wb_arbiter_if.slave  lsu,
  output logic             we3,
  output logic [IW-1:0]    v3,
  output logic [WIDTH-1:0] wd3 [VECTOR_SIZE],
  input  logic             issue_valid,
  input  logic [IW-1:0]    issue_vd,
  output logic             issue_ready,
  input  logic [IW-1:0]    q_v1,
  input  logic [IW-1:0]    q_v2,
  output logic             hazard_v1,
  output logic             hazard_v2,
  output logic             err_underflow
);

  req_id_t          last_q, last_d;
  logic             we3_q, we3_d;
  logic [IW-1:0]    v3_q, v3_d;
  logic [WIDTH-1:0] wd3_q [VECTOR_SIZE];
  logic [WIDTH-1:0] wd3_d [VECTOR_SIZE];
  logic             gnt_alu, gnt_lsu;

  // On a tie the requester that did not win last time goes first.
  assign gnt_alu   = alu.valid && (!lsu.valid || (last_q == REQ_LSU));
  assign gnt_lsu   = lsu.valid && !gnt_alu;
  assign alu.ready = gnt_alu;
  assign lsu.ready = gnt_lsu;

  always_comb begin
    we3_d  = 1'b0;
    v3_d   = v3_q;
    wd3_d  = wd3_q;
    last_d = last_q;
    // v0 is hard-wired zero: the transfer is acknowledged but never written.
    if (gnt_alu) begin
      we3_d  = (alu.vd != '0);
      v3_d   = alu.vd;
      wd3_d  = alu.data;
      last_d = REQ_ALU;
    end else if (gnt_lsu) begin
      we3_d  = (lsu.vd != '0);
      v3_d   = lsu.vd;
      wd3_d  = lsu.data;
      last_d = REQ_LSU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3_q  <= 1'b0;
      v3_q   <= '0;
      wd3_q  <= '{default: '0};
      last_q <= REQ_LSU;
    end else begin
      we3_q  <= we3_d;
      v3_q   <= v3_d;
      wd3_q  <= wd3_d;
      last_q <= last_d;
    end
  end

  assign we3 = we3_q;
  assign v3  = v3_q;
  assign wd3 = wd3_q;

  vrf_scoreboard #(
    .NUM_VECTORES (NUM_VECTORES),
    .CNT_W        (CNT_W),
    .IW           (IW)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_vd      (issue_vd),
    .issue_ready   (issue_ready),
    .wr_en         (we3_q),
    .wr_idx        (v3_q),
    .q_v1          (q_v1),
    .q_v2          (q_v2),
    .hazard_v1     (hazard_v1),
    .hazard_v2     (hazard_v2),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Self-checking bench for vrf_wb_arbiter: cycle model plus expected-write queue.
module tb_vrf_wb_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned VS = 16;
  localparam int unsigned NV = 16;
  localparam int unsigned IW = 4;

  typedef struct packed {
    logic          we;
    logic [IW-1:0] vd;
    logic [W*VS-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          we3;
  logic [IW-1:0] v3;
  logic [W-1:0]  wd3 [VS];
  logic          issue_valid;
  logic [IW-1:0] issue_vd;
  logic          issue_ready;
  logic [IW-1:0] q_v1, q_v2;
  logic          hazard_v1, hazard_v2;
  logic          err_underflow;

  vrf_wb_arbiter_if #(.WIDTH(W), .VECTOR_SIZE(VS), .IW(IW)) alu_bus ();
  vrf_wb_arbiter_if #(.WIDTH(W), .VECTOR_SIZE(VS), .IW(IW)) lsu_bus ();

  vrf_wb_arbiter #(
    .WIDTH        (W),
    .VECTOR_SIZE  (VS),
    .NUM_VECTORES (NV),
    .CNT_W        (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu           (alu_bus),
    .lsu           (lsu_bus),
    .we3           (we3),
    .v3            (v3),
    .wd3           (wd3),
    .issue_valid   (issue_valid),
    .issue_vd      (issue_vd),
    .issue_ready   (issue_ready),
    .q_v1          (q_v1),
    .q_v2          (q_v2),
    .hazard_v1     (hazard_v1),
    .hazard_v2     (hazard_v2),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  wr_t  exp_q [$];
  int   mcnt [NV];
  logic m_err;
  logic m_last_lsu;
  wr_t  cur, nxt;
  logic g_alu, g_lsu, exp_rdy, inc;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int r = 0; r < NV; r++) mcnt[r] = 0;
      m_err      = 1'b0;
      m_last_lsu = 1'b1;
    end else begin
      cur = '0;
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      check_val("we3", {31'd0, we3}, {31'd0, cur.we});
      if (cur.we) begin
        check_val("v3", {28'd0, v3}, {28'd0, cur.vd});
        for (int i = 0; i < VS; i++) begin
          check_val("wd3", {16'd0, wd3[i]}, {16'd0, cur.data[i*W +: W]});
        end
      end
      exp_rdy = (mcnt[issue_vd] != 3);
      check_val("issue_ready", {31'd0, issue_ready}, {31'd0, exp_rdy});
      check_val("hazard_v1", {31'd0, hazard_v1}, {31'd0, (q_v1 != 0) && (mcnt[q_v1] != 0)});
      check_val("hazard_v2", {31'd0, hazard_v2}, {31'd0, (q_v2 != 0) && (mcnt[q_v2] != 0)});
      check_val("err_underflow", {31'd0, err_underflow}, {31'd0, m_err});

      g_alu = alu_bus.valid && (!lsu_bus.valid || m_last_lsu);
      g_lsu = lsu_bus.valid && !g_alu;
      check_val("alu_ready", {31'd0, alu_bus.ready}, {31'd0, g_alu});
      check_val("lsu_ready", {31'd0, lsu_bus.ready}, {31'd0, g_lsu});

      nxt    = '0;
      nxt.we = (g_alu && alu_bus.vd != 0) || (g_lsu && lsu_bus.vd != 0);
      nxt.vd = g_alu ? alu_bus.vd : lsu_bus.vd;
      for (int i = 0; i < VS; i++) begin
        nxt.data[i*W +: W] = g_alu ? alu_bus.data[i] : lsu_bus.data[i];
      end
      if (g_alu || g_lsu) exp_q.push_back(nxt);
      if (g_alu) m_last_lsu = 1'b0;
      else if (g_lsu) m_last_lsu = 1'b1;

      inc = issue_valid && exp_rdy && (issue_vd != 0);
      if (inc && !(cur.we && cur.vd == issue_vd)) mcnt[issue_vd]++;
      if (cur.we && !(inc && issue_vd == cur.vd)) begin
        if (mcnt[cur.vd] == 0) m_err = 1'b1;
        else mcnt[cur.vd]--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic is_lsu, input logic [15:0] base);
    for (int i = 0; i < VS; i++) begin
      if (is_lsu) lsu_bus.data[i] = base + 16'(i);
      else        alu_bus.data[i] = base + 16'(i);
    end
  endtask

  task automatic clear_inputs();
    alu_bus.valid = 1'b0;
    alu_bus.vd    = '0;
    lsu_bus.valid = 1'b0;
    lsu_bus.vd    = '0;
    issue_valid   = 1'b0;
    issue_vd      = '0;
    q_v1          = '0;
    q_v2          = '0;
    fill(1'b0, 16'h0);
    fill(1'b1, 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_we3"}, {31'd0, we3}, 32'd0);
    check_val({tag, "_v3"}, {28'd0, v3}, 32'd0);
    check_val({tag, "_wd3_0"}, {16'd0, wd3[0]}, 32'd0);
    check_val({tag, "_wd3_15"}, {16'd0, wd3[15]}, 32'd0);
    check_val({tag, "_hz1"}, {31'd0, hazard_v1}, 32'd0);
    check_val({tag, "_hz2"}, {31'd0, hazard_v2}, 32'd0);
    check_val({tag, "_issue_ready"}, {31'd0, issue_ready}, 32'd1);
    check_val({tag, "_err"}, {31'd0, err_underflow}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    check_reset_outputs("rst0");
    step();
    step();
    rst = 1'b0;
    step();

    // Single ALU write with RAW hazard on v5
    issue_valid = 1'b1; issue_vd = 4'd5; q_v1 = 4'd5;
    step();
    issue_valid = 1'b0;
    alu_bus.valid = 1'b1; alu_bus.vd = 4'd5;
    for (int i = 0; i < VS; i++) alu_bus.data[i] = 16'h1234;
    step();
    alu_bus.valid = 1'b0;
    step();
    step();

    // Contention: ALU->v3, LSU->v4, two transfers each
    issue_valid = 1'b1; issue_vd = 4'd3; q_v1 = 4'd3; q_v2 = 4'd4;
    step();
    step();
    issue_vd = 4'd4;
    step();
    step();
    issue_valid = 1'b0;
    alu_bus.valid = 1'b1; alu_bus.vd = 4'd3; fill(1'b0, 16'hA000);
    lsu_bus.valid = 1'b1; lsu_bus.vd = 4'd4; fill(1'b1, 16'hB000);
    step();
    fill(1'b0, 16'hA100);
    step();
    fill(1'b1, 16'hB100);
    step();
    step();
    alu_bus.valid = 1'b0;
    lsu_bus.valid = 1'b0;
    step();
    step();

    // Write to v0: acknowledged, never committed
    lsu_bus.valid = 1'b1; lsu_bus.vd = 4'd0; fill(1'b1, 16'hC000);
    step();
    lsu_bus.valid = 1'b0;
    step();
    step();

    // Saturation on v7; issue held across the stall
    issue_valid = 1'b1; issue_vd = 4'd7; q_v1 = 4'd7;
    step();
    step();
    step();
    alu_bus.valid = 1'b1; alu_bus.vd = 4'd7; fill(1'b0, 16'h7700);
    step();
    alu_bus.valid = 1'b0;
    step();
    step();
    issue_valid = 1'b0;
    lsu_bus.valid = 1'b1; lsu_bus.vd = 4'd7; fill(1'b1, 16'h7100);
    step();
    fill(1'b1, 16'h7200);
    step();
    fill(1'b1, 16'h7300);
    step();
    lsu_bus.valid = 1'b0;
    step();
    step();

    // Underflow: write to v9 with nothing issued
    lsu_bus.valid = 1'b1; lsu_bus.vd = 4'd9; q_v2 = 4'd9; fill(1'b1, 16'h9900);
    step();
    lsu_bus.valid = 1'b0;
    step();
    step();

    // Asynchronous reset while a write and a hazard are live
    issue_valid = 1'b1; issue_vd = 4'd2; q_v1 = 4'd2;
    step();
    issue_valid = 1'b0;
    alu_bus.valid = 1'b1; alu_bus.vd = 4'd2; fill(1'b0, 16'h5550);
    step();
    alu_bus.valid = 1'b0;
    #2;
    check_val("pre_rst_we3", {31'd0, we3}, 32'd1);
    check_val("pre_rst_hz1", {31'd0, hazard_v1}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
